// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder controller
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/Add_full.sv
// rtl/Add_full.sv - one-bit full-adder cell
module Add_full (
    output logic soma,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    // Sum and majority carry of the three input bits
    assign soma = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder: one full-adder cell reused LSB first over WIDTH cycles
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] soma,
    output logic             cout
);

    // Counter only needs to reach WIDTH-1, so it never wraps inside an operation.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_cout;

    Add_full u_fa (
        .soma (fa_sum),
        .cout (fa_cout),
        .a    (op_a[cnt]),
        .b    (op_b[cnt]),
        .cin  (carry)
    );

    // Partial result with the current bit slot filled in by the adder cell
    always_comb begin
        result_next      = result;
        result_next[cnt] = fa_sum;
    end

    // Sequencer: capture operands, walk the bits, publish the result once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            op_a   <= '0;
            op_b   <= '0;
            carry  <= 1'b0;
            result <= '0;
            cnt    <= '0;
            soma   <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_a   <= a;
                        op_b   <= b;
                        carry  <= cin;
                        result <= '0;
                        cnt    <= '0;
                        state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    result <= result_next;
                    carry  <= fa_cout;
                    if (cnt == LAST_BIT) begin
                        soma  <= result_next;
                        cout  <= fa_cout;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status flags follow directly from the registered state
    assign busy = (state == ST_SHIFT);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl at WIDTH=8
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] soma;
    logic             cout;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .soma  (soma),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: an operation is accepted when idle and start is seen, the sum
    // appears WIDTH edges later with done, and one more edge frees the block.
    int ecount    = 0;
    bit m_active  = 0;
    int m_acc     = 0;
    int m_pending = 0;
    int m_soma    = 0;
    int m_cout    = 0;
    int ops_done  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0;
            m_soma   = 0;
            m_cout   = 0;
        end else begin
            ecount++;
            if (m_active) begin
                if (ecount - m_acc == WIDTH) begin
                    m_soma = m_pending % (1 << WIDTH);
                    m_cout = m_pending >> WIDTH;
                    ops_done++;
                end else if (ecount - m_acc == WIDTH + 1) begin
                    m_active = 0;
                end
            end else if (start) begin
                m_active  = 1;
                m_acc     = ecount;
                m_pending = int'(a) + int'(b) + int'(cin);
            end
        end
    end

    bit chk_en = 0;

    // Compare every outputs against the reference once per cycle
    always @(negedge clk) begin : cmp
        int d;
        if (chk_en) begin
            d = ecount - m_acc;
            check("busy", busy, (m_active && d < WIDTH) ? 1 : 0);
            check("done", done, (m_active && d == WIDTH) ? 1 : 0);
            check("soma", soma, m_soma);
            check("cout", cout, m_cout);
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic tc, input int inj, input int rst_at,
                          output int lat, output int nbusy);
        bit fin;
        lat   = 0;
        nbusy = 0;
        fin   = 0;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
        while (!fin && lat < 40) begin
            if (done) begin
                fin = 1;
            end else begin
                if (busy) nbusy++;
                if (inj != 0 && busy && nbusy == inj) begin
                    start = 1'b1; a = '1; b = '1;
                end else begin
                    start = 1'b0;
                end
                if (rst_at != 0 && nbusy == rst_at) begin
                    #2 rst = 1'b1;
                    #1;
                    check("abort busy", busy, 0);
                    check("abort done", done, 0);
                    check("abort soma", soma, 0);
                    check("abort cout", cout, 0);
                    @(negedge clk);
                    #2 rst = 1'b0;
                    start = 1'b0;
                    return;
                end
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        check("op finished", fin, 1);
    endtask

    int lat, nbusy, base, cyc, idx;
    int pulses[$];

    initial begin
        chk_en = 1;
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset soma", soma, 0);
        check("reset cout", cout, 0);
        #2 rst = 1'b0;

        run_op(8'h00, 8'h00, 1'b1, 0, 0, lat, nbusy);
        check("t1 busy cycles", nbusy, 8);
        check("t1 latency", lat + 1, 9);
        check("t1 soma", soma, 8'h01);
        check("t1 cout", cout, 0);

        run_op(8'hFF, 8'h01, 1'b0, 0, 0, lat, nbusy);
        check("t2 soma", soma, 8'h00);
        check("t2 cout", cout, 1);

        run_op(8'h3C, 8'h42, 1'b0, 3, 0, lat, nbusy);
        check("t3 soma", soma, 8'h7E);
        check("t3 cout", cout, 0);
        repeat (3) @(negedge clk);
        check("t3 no second op", done, 0);

        run_op(8'hFF, 8'hFF, 1'b1, 0, 4, lat, nbusy);
        repeat (12) begin
            @(negedge clk);
            check("t4 no done after abort", done, 0);
        end
        run_op(8'h01, 8'h01, 1'b0, 0, 0, lat, nbusy);
        check("t4 soma", soma, 8'h02);
        check("t4 cout", cout, 0);

        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        idx = 0;
        repeat (42) begin
            @(negedge clk);
            idx++;
            if (done) begin
                pulses.push_back(idx);
                check("t5 soma", soma, 8'h30);
            end
        end
        start = 1'b0;
        check("t5 pulse count", pulses.size(), 4);
        for (int i = 1; i < pulses.size(); i++)
            check("t5 period", pulses[i] - pulses[i-1], 10);
        repeat (WIDTH + 3) @(negedge clk);

        base = ops_done;
        cyc  = 0;
        while (cyc < 40000 && ops_done - base < 1000) begin
            @(negedge clk);
            cyc++;
            start = ($urandom % 3) != 0;
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            cin   = 1'($urandom);
            if ($urandom % 600 == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
        end
        start = 1'b0;
        check("random ops completed", (ops_done - base >= 1000) ? 1 : 0, 1);
        repeat (WIDTH + 3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
